// File: rtl/preg_stage.sv
// rtl/preg_stage.sv - parametrised pipeline stage register with optional skid entry and flush
module preg_stage #(
    parameter int CTRL_WIDTH         = 16,
    parameter int DATA_WIDTH         = 64,
    parameter bit SKID               = 1'b1,
    parameter bit ZERO_DATA_ON_FLUSH = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [CTRL_WIDTH-1:0] i_ctrl,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [CTRL_WIDTH-1:0] o_ctrl,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_occupancy
);

    logic                  out_valid;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  skid_valid;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  out_free;
    logic                  accept;

    // Handshake: output slot frees when empty or draining; skid mode takes ready from the skid flag only
    always_comb begin
        out_free = ~out_valid | i_ready;
        if (i_flush) begin
            o_ready = 1'b0;
        end else if (SKID) begin
            o_ready = ~skid_valid;
        end else begin
            o_ready = out_free;
        end
        accept = i_valid & o_ready;
    end

    // Output and skid entries: skid beat always moves ahead of any new beat to keep order
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (i_flush) begin
            out_valid  <= 1'b0;
            out_ctrl   <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            if (ZERO_DATA_ON_FLUSH) begin
                out_data  <= '0;
                skid_data <= '0;
            end
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_ctrl   <= skid_ctrl;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
                skid_ctrl  <= '0;
                skid_data  <= '0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_ctrl  <= i_ctrl;
                out_data  <= i_data;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept && SKID) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= i_ctrl;
            skid_data  <= i_data;
        end
    end

    // Bubbles carry an all-zero control bundle so they act as NOPs downstream
    always_comb begin
        o_valid     = out_valid;
        o_ctrl      = out_ctrl & {CTRL_WIDTH{out_valid}};
        o_data      = out_data;
        o_occupancy = {1'b0, out_valid} + {1'b0, skid_valid};
    end

endmodule
